// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// States, error codes and prefix bytes used by frame and decoder logic.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam logic [1:0] ERR_START   = 2'd0;
   localparam logic [1:0] ERR_PARITY  = 2'd1;
   localparam logic [1:0] ERR_STOP    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam logic [7:0] E0 = 8'hE0;
   localparam logic [7:0] F0 = 8'hF0;
   localparam logic [7:0] E1 = 8'hE1;

   function automatic logic is_status(input logic [7:0] b);
      return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
   endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Output bundle of the PS/2 keyboard receiver.
// master drives it, slave consumes it.
interface ps2_kbd_rx_if;

   logic [7:0] rx_byte;
   logic       rx_strobe;
   logic       err_strobe;
   logic [1:0] err_code;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_release;
   logic       key_strobe;

   modport master (
      output rx_byte, rx_strobe, err_strobe, err_code,
      output key_code, key_ext, key_release, key_strobe
   );

   modport slave (
      input rx_byte, rx_strobe, err_strobe, err_code,
      input key_code, key_ext, key_release, key_strobe
   );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronizer, bit FSM and watchdog.
// Emits good bytes or a framing error code.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int TIMEOUT = 20000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic [7:0] rx_byte,
   output logic       rx_strobe,
   output logic       err_strobe,
   output logic [1:0] err_code
);

   localparam logic [14:0] TO = 15'(TIMEOUT);

   logic [1:0]  c_sync, d_sync;
   logic        c_prev;
   logic        fall, bit_d;
   rx_state_t   state, nxt;
   logic [2:0]  idx, idx_n;
   logic [7:0]  sh, sh_n;
   logic        par, par_n;
   logic [14:0] cnt, cnt_n;
   logic [7:0]  byte_n;
   logic        rxs_n, errs_n;
   logic [1:0]  code_n;

   assign fall  = c_prev & ~c_sync[1];
   assign bit_d = d_sync[1];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         c_sync     <= 2'b11;
         d_sync     <= 2'b11;
         c_prev     <= 1'b1;
         state      <= IDLE;
         idx        <= '0;
         sh         <= '0;
         par        <= 1'b0;
         cnt        <= '0;
         rx_byte    <= '0;
         rx_strobe  <= 1'b0;
         err_strobe <= 1'b0;
         err_code   <= '0;
      end else begin
         c_sync     <= {c_sync[0], ps2_clk_in};
         d_sync     <= {d_sync[0], ps2_data_in};
         c_prev     <= c_sync[1];
         state      <= nxt;
         idx        <= idx_n;
         sh         <= sh_n;
         par        <= par_n;
         cnt        <= cnt_n;
         rx_byte    <= byte_n;
         rx_strobe  <= rxs_n;
         err_strobe <= errs_n;
         err_code   <= code_n;
      end
   end

   always_comb begin
      nxt    = state;
      idx_n  = idx;
      sh_n   = sh;
      par_n  = par;
      byte_n = rx_byte;
      rxs_n  = 1'b0;
      errs_n = 1'b0;
      code_n = err_code;
      cnt_n  = cnt;
      // saturating watchdog, restarted by every clock edge
      if (state != IDLE && cnt != 15'h7FFF)
         cnt_n = cnt + 15'd1;
      if (fall)
         cnt_n = '0;
      if (state != IDLE && cnt >= TO) begin
         nxt    = IDLE;
         errs_n = 1'b1;
         code_n = ERR_TIMEOUT;
      end else if (fall) begin
         unique case (state)
            IDLE: begin
               if (!bit_d) begin
                  nxt   = DATA;
                  idx_n = '0;
               end else begin
                  errs_n = 1'b1;
                  code_n = ERR_START;
               end
            end
            DATA: begin
               sh_n[idx] = bit_d;
               idx_n     = idx + 3'd1;
               if (idx == 3'd7)
                  nxt = PARITY;
            end
            PARITY: begin
               par_n = bit_d;
               nxt   = STOP;
            end
            STOP: begin
               nxt = IDLE;
               if (!(^{sh, par})) begin
                  errs_n = 1'b1;
                  code_n = ERR_PARITY;
               end else if (!bit_d) begin
                  errs_n = 1'b1;
                  code_n = ERR_STOP;
               end else begin
                  byte_n = sh;
                  rxs_n  = 1'b1;
               end
            end
            default: nxt = IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver top: frame receiver plus prefix decoder
// turning bytes into key events (code, extended, release).
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int TIMEOUT = 20000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                ps2_clk_in,
   input  logic                ps2_data_in,
   ps2_kbd_rx_if.master        bus
);

   logic [7:0] rx_byte;
   logic       rx_stb, err_stb;
   logic [1:0] err_code;
   logic       pend_ext, pend_rel;
   logic [2:0] skip;
   logic [7:0] key_code;
   logic       key_ext, key_rel, key_stb;

   ps2_frame_rx #(.TIMEOUT(TIMEOUT)) u_frame (
      .clk        (clk),
      .reset_n    (reset_n),
      .ps2_clk_in (ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .rx_byte    (rx_byte),
      .rx_strobe  (rx_stb),
      .err_strobe (err_stb),
      .err_code   (err_code)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pend_ext <= 1'b0;
         pend_rel <= 1'b0;
         skip     <= '0;
         key_code <= '0;
         key_ext  <= 1'b0;
         key_rel  <= 1'b0;
         key_stb  <= 1'b0;
      end else begin
         key_stb <= 1'b0;
         if (err_stb) begin
            pend_ext <= 1'b0;
            pend_rel <= 1'b0;
            skip     <= '0;
         end else if (rx_stb) begin
            if (skip != 3'd0) begin
               skip <= skip - 3'd1;
            end else if (rx_byte == E0) begin
               pend_ext <= 1'b1;
            end else if (rx_byte == F0) begin
               pend_rel <= 1'b1;
            end else if (rx_byte == E1) begin
               // pause: report once, drop the rest of its sequence
               key_code <= E1;
               key_ext  <= 1'b0;
               key_rel  <= 1'b0;
               key_stb  <= 1'b1;
               skip     <= 3'd7;
               pend_ext <= 1'b0;
               pend_rel <= 1'b0;
            end else if (!pend_ext && !pend_rel && is_status(rx_byte)) begin
               skip <= '0;
            end else begin
               key_code <= rx_byte;
               key_ext  <= pend_ext;
               key_rel  <= pend_rel;
               key_stb  <= 1'b1;
               pend_ext <= 1'b0;
               pend_rel <= 1'b0;
            end
         end
      end
   end

   assign bus.rx_byte     = rx_byte;
   assign bus.rx_strobe   = rx_stb;
   assign bus.err_strobe  = err_stb;
   assign bus.err_code    = err_code;
   assign bus.key_code    = key_code;
   assign bus.key_ext     = key_ext;
   assign bus.key_release = key_rel;
   assign bus.key_strobe  = key_stb;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: directed cases plus random frames
// checked against a byte/key reference model.
module tb_ps2_kbd_rx;

   localparam int TO = 300;

   typedef struct {
      logic [7:0] code;
      logic       ext;
      logic       rel;
   } key_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;

   ps2_kbd_rx_if bus ();

   ps2_kbd_rx #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ps2_clk_in (ps2_clk),
      .ps2_data_in(ps2_data),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   int H = 4;
   int t_edge = 0, t_rx = -1, t_err = -1, t_key = -1;

   logic [7:0] exp_rx[$];
   logic [1:0] exp_err[$];
   key_t       exp_key[$];

   logic       m_ext = 1'b0, m_rel = 1'b0;
   int         m_skip = 0;
   logic [7:0] status_tab[8] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE,
                                 8'h00, 8'hFF, 8'hE0, 8'hF0};

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic unexp(input string name, input int act);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: unexpected strobe, value %0h", name, act);
   endtask

   // reference decoder: prefix flags, pause skip, status filtering
   task automatic model_byte(input logic [7:0] b);
      bit st;
      st = 0;
      for (int i = 0; i < 6; i++)
         if (status_tab[i] == b) st = 1;
      if (m_skip > 0) m_skip--;
      else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_rel = 1;
      else if (b == 8'hE1) begin
         exp_key.push_back('{8'hE1, 1'b0, 1'b0});
         m_skip = 7;
         m_ext = 0;
         m_rel = 0;
      end else if (!(st && !m_ext && !m_rel)) begin
         exp_key.push_back('{b, m_ext, m_rel});
         m_ext = 0;
         m_rel = 0;
      end
   endtask

   task automatic model_clear();
      m_ext = 0;
      m_rel = 0;
      m_skip = 0;
   endtask

   always @(negedge clk) begin
      if (bus.rx_strobe && bus.err_strobe)
         unexp("rx_err_same_cycle", 1);
      if (bus.rx_strobe) begin
         t_rx = cyc;
         if (exp_rx.size() == 0) unexp("rx_byte", bus.rx_byte);
         else chk("rx_byte", bus.rx_byte, exp_rx.pop_front());
      end
      if (bus.err_strobe) begin
         t_err = cyc;
         if (exp_err.size() == 0) unexp("err_code", bus.err_code);
         else chk("err_code", bus.err_code, exp_err.pop_front());
      end
      if (bus.key_strobe) begin
         t_key = cyc;
         if (exp_key.size() == 0) unexp("key", bus.key_code);
         else begin
            key_t k;
            k = exp_key.pop_front();
            chk("key_code", bus.key_code, k.code);
            chk("key_ext", bus.key_ext, k.ext);
            chk("key_release", bus.key_release, k.rel);
         end
      end
   end

   task automatic half();
      repeat (H) @(negedge clk);
   endtask

   task automatic ps2_edge(input logic b);
      ps2_data = b;
      half();
      ps2_clk = 1'b0;
      t_edge = cyc;
      half();
      ps2_clk = 1'b1;
   endtask

   task automatic send_raw(input logic [7:0] b, input bit pbad,
                           input bit sbad);
      if (pbad) begin
         exp_err.push_back(2'd1);
         model_clear();
      end else if (sbad) begin
         exp_err.push_back(2'd2);
         model_clear();
      end else begin
         exp_rx.push_back(b);
         model_byte(b);
      end
      ps2_edge(1'b0);
      for (int i = 0; i < 8; i++) ps2_edge(b[i]);
      ps2_edge((~^b) ^ pbad);
      ps2_edge(~sbad);
      ps2_data = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      send_raw(b, 0, 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rx_byte"}, bus.rx_byte, 0);
      chk({tag, "_rx_strobe"}, bus.rx_strobe, 0);
      chk({tag, "_err_strobe"}, bus.err_strobe, 0);
      chk({tag, "_err_code"}, bus.err_code, 0);
      chk({tag, "_key_code"}, bus.key_code, 0);
      chk({tag, "_key_ext"}, bus.key_ext, 0);
      chk({tag, "_key_rel"}, bus.key_release, 0);
      chk({tag, "_key_strobe"}, bus.key_strobe, 0);
   endtask

   initial begin
      logic [7:0] b;
      int r;
      repeat (4) @(negedge clk);
      chk_zero("reset");
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // single make code with latency checks
      send(8'h1C);
      repeat (4) @(negedge clk);
      chk("rx_latency", t_rx - t_edge, 3);
      chk("key_latency", t_key - t_edge, 4);

      send(8'hE0);
      send(8'hF0);
      send(8'h75);

      send_raw(8'h1C, 1, 0);
      send(8'hE0);
      send(8'h75);

      // abort after five edges and let the watchdog fire
      exp_err.push_back(2'd3);
      model_clear();
      t_err = -1;
      ps2_edge(1'b0);
      for (int i = 0; i < 4; i++) ps2_edge(1'($urandom_range(0, 1)));
      repeat (TO + 10) @(negedge clk);
      // 3 cycles input latency, TO counts, 1 registered strobe
      chk("timeout_latency", t_err - t_edge, TO + 4);
      send(8'h29);

      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      send(8'hAA);

      // reset in the middle of bit 4
      ps2_edge(1'b0);
      for (int i = 0; i < 4; i++) ps2_edge(1'b1);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("midreset");
      reset_n = 1'b1;
      model_clear();
      repeat (6) @(negedge clk);
      send(8'h5A);

      for (int n = 0; n < 80; n++) begin
         H = $urandom_range(4, 7);
         r = $urandom_range(0, 19);
         if ($urandom_range(0, 3) == 0) b = status_tab[$urandom_range(0, 7)];
         else b = 8'($urandom_range(0, 255));
         if (b == 8'hE1) b = 8'h1C;
         if (r == 0) begin
            exp_err.push_back(2'd0);
            model_clear();
            ps2_edge(1'b1);
         end else if (r == 1) send_raw(b, 1, 0);
         else if (r == 2) send_raw(b, 0, 1);
         else if (r == 3) send_raw(b, 1, 1);
         else send(b);
         repeat ($urandom_range(0, 6)) @(negedge clk);
      end

      repeat (50) @(negedge clk);
      chk("rx_queue_left", exp_rx.size(), 0);
      chk("err_queue_left", exp_err.size(), 0);
      chk("key_queue_left", exp_key.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
